param_ram: RTL and testbench
============================

PARAM_RAM -- requirements
Module: param_ram

Interface
REQ-001 The module SHALL expose parameter DATA_W, default 4, data word width in bits.
REQ-002 The module SHALL expose parameter ADDR_W, default 6, address width in bits.
REQ-003 The module SHALL expose parameter DEPTH, default 64, number of words; legal range 2..2**ADDR_W.
REQ-004 The module SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 The module SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 The module SHALL have port clr  input  1  soft-clear request; starts a zeroing sweep of the whole array.
REQ-007 The module SHALL have port we  input  1  write enable.
REQ-008 The module SHALL have port waddr  input  ADDR_W  write address.
REQ-009 The module SHALL have port wdata  input  DATA_W  write data.
REQ-010 The module SHALL have port re  input  1  read enable.
REQ-011 The module SHALL have port raddr  input  ADDR_W  read address.
REQ-012 The module SHALL have port rdata  output  DATA_W  registered read data.
REQ-013 The module SHALL have port rvalid  output  1  one-cycle pulse qualifying rdata.
REQ-014 The module SHALL have port busy  output  1  high while the clear sweep runs; all accesses are ignored while high.

Function
REQ-015 Storage SHALL be DEPTH words of DATA_W bits; one write port and one read port; both usable in the same cycle.
REQ-016 The FSM SHALL have two states: IDLE and CLEAR; busy = (state == CLEAR), combinational from state.
REQ-017 CLEAR SHALL write zero to mem[cnt] each cycle and increment cnt, with cnt ADDR_W bits wide starting at 0.
REQ-018 CLEAR SHALL last exactly DEPTH cycles; the cycle that writes mem[DEPTH-1] transitions to IDLE, so busy is low on the next cycle.
REQ-019 In IDLE, clr=1 SHALL move to CLEAR with cnt<=0 at the next edge; a write issued in the same cycle as clr SHALL be discarded (clr wins).
REQ-020 clr asserted during CLEAR SHALL be ignored; the sweep SHALL neither restart nor extend.
REQ-021 In IDLE, we=1 with waddr<DEPTH SHALL write wdata to mem[waddr] at the edge; waddr>=DEPTH SHALL be ignored.
REQ-022 In IDLE, re=1 SHALL register rdata<=mem[raddr] and rvalid<=1 at the edge, giving 1-cycle latency; raddr>=DEPTH SHALL return 0, still with rvalid=1.
REQ-023 With re=0 or busy=1, rvalid SHALL be 0 on the next cycle and rdata SHALL hold its previous value.
REQ-024 A read and a write to the same address in the same IDLE cycle SHALL be write-first: rdata returns the new wdata.
REQ-025 Back-to-back reads SHALL be sustainable at one per cycle with no bubbles.

Reset
REQ-026 rst=1 at an edge SHALL set state=CLEAR, cnt=0, rdata=0 and rvalid=0; it takes priority over clr, we and re.
REQ-027 While rst is held high, busy SHALL be 1 and cnt SHALL stay 0; the DEPTH-cycle sweep SHALL begin on the first edge with rst=0.
REQ-028 rst asserted mid-sweep or mid-operation SHALL restart the sweep from cnt=0.
REQ-029 After reset completes, every word SHALL read 0.

Verification
REQ-030 The bench SHALL cover reset: rst high 1 cycle, then low -> busy high exactly 64 cycles, low on cycle 65; reads of addr 0 and 63 return 0 with rvalid=1.
REQ-031 The bench SHALL cover write/read: write 4'hF@0, then 4'hA@4; re@0 then re@4 on consecutive cycles -> rdata F then A, one cycle after each re, with rvalid high 2 consecutive cycles.
REQ-032 The bench SHALL cover same-address collision: we=1 and re=1 both @7 with wdata=4'h5 -> next cycle rdata=5 and rvalid=1.
REQ-033 The bench SHALL cover accesses while busy: during the sweep, we@3 with 4'h9 and re@3 -> rvalid stays 0; after the sweep, re@3 returns 0.
REQ-034 The bench SHALL cover clr with a pending write: mem@10=4'hC, then clr=1 and we@11 with 4'h6 in the same cycle -> 64 busy cycles; afterwards addr 10 and addr 11 both read 0.
REQ-035 The bench SHALL cover rst mid-sweep and a small DEPTH: assert rst at sweep cycle 30 -> busy lasts 64 cycles after rst falls; with DEPTH=40 and ADDR_W=6, we@50 is ignored and re@50 returns 0.

Source files
------------

// File: rtl/param_ram_if.sv
// param_ram_if: access bundle for param_ram.
//   master drives: clr, we, waddr, wdata, re, raddr
//   slave drives:  rdata, rvalid, busy
interface param_ram_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 6
) ();
    logic              clr;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              busy;

    modport master (
        output clr, we, waddr, wdata, re, raddr,
        input  rdata, rvalid, busy
    );

    modport slave (
        input  clr, we, waddr, wdata, re, raddr,
        output rdata, rvalid, busy
    );
endinterface

// File: rtl/param_ram.sv
// param_ram: DEPTH x DATA_W simple dual-port RAM with a zeroing sweep.
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset; starts a full zeroing sweep
//   bus  - param_ram_if.slave:
//          clr           soft-clear request (ignored while busy)
//          we/waddr/wdata write port, out-of-range addresses dropped
//          re/raddr      read port, 1-cycle latency, write-first on collision
//          rdata/rvalid  registered read data and its one-cycle qualifier
//          busy          high while the sweep runs; all accesses ignored then
module param_ram #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input logic         clk,
    input logic         rst,
    param_ram_if.slave  bus
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    // DEPTH may equal 2**ADDR_W, so range checks need one extra bit.
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_next;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    logic              idle;
    logic              wr_ok;
    logic              rd_in_range;

    assign idle        = (state == IDLE);
    // clr in the same cycle discards the write.
    assign wr_ok       = idle && !bus.clr && bus.we && ({1'b0, bus.waddr} < DEPTH_L);
    assign rd_in_range = ({1'b0, bus.raddr} < DEPTH_L);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Sweep walks cnt 0..DEPTH-1; the cycle clearing the last word returns to IDLE.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (bus.clr) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                cnt_next = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[cnt] <= '0;
            end else if (wr_ok) begin
                mem[bus.waddr] <= bus.wdata;
            end
        end
    end

    // Read port: rdata holds when no read is accepted; a same-address write
    // in the same cycle is forwarded so the read sees the new data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            if (idle && bus.re) begin
                rvalid_q <= 1'b1;
                if (!rd_in_range) begin
                    rdata_q <= '0;
                end else if (wr_ok && (bus.waddr == bus.raddr)) begin
                    rdata_q <= bus.wdata;
                end else begin
                    rdata_q <= mem[bus.raddr];
                end
            end
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.busy   = (state == CLEAR);

endmodule

// File: tb/tb_param_ram.sv
// tb_param_ram: directed self-checking bench for param_ram.
//   dut   - default configuration (DATA_W=4, ADDR_W=6, DEPTH=64)
//   dut_s - reduced depth (DEPTH=40, ADDR_W=6) for out-of-range handling
module tb_param_ram;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   n;

    param_ram_if #(.DATA_W(4), .ADDR_W(6)) bus ();
    param_ram_if #(.DATA_W(4), .ADDR_W(6)) bus_s ();

    param_ram #(.DATA_W(4), .ADDR_W(6), .DEPTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    param_ram #(.DATA_W(4), .ADDR_W(6), .DEPTH(40)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic clr, input logic we, input logic [5:0] waddr,
                                 input logic [3:0] wdata, input logic re, input logic [5:0] raddr);
        bus.clr   = clr;
        bus.we    = we;
        bus.waddr = waddr;
        bus.wdata = wdata;
        bus.re    = re;
        bus.raddr = raddr;
    endtask

    task automatic applyStimulusS(input logic we, input logic [5:0] waddr,
                                  input logic [3:0] wdata, input logic re, input logic [5:0] raddr);
        bus_s.clr   = 1'b0;
        bus_s.we    = we;
        bus_s.waddr = waddr;
        bus_s.wdata = wdata;
        bus_s.re    = re;
        bus_s.raddr = raddr;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
            $error("[TB] check %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Counts busy cycles starting at the current sample, bounded so a stuck
    // busy shows up as a wrong count instead of a hang.
    task automatic countBusy(output int cycles);
        cycles = 0;
        for (int i = 0; i < 200 && bus.busy; i++) begin
            cycles++;
            tick();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        applyStimulus(1'b0, 1'b0, 6'd0, 4'h0, 1'b0, 6'd0);
        applyStimulusS(1'b0, 6'd0, 4'h0, 1'b0, 6'd0);

        // Reset: one cycle of rst, then a 64-cycle sweep.
        tick();
        checkOutput("rst_busy", int'(bus.busy), 1);
        checkOutput("rst_rvalid", int'(bus.rvalid), 0);
        checkOutput("rst_rdata", int'(bus.rdata), 0);
        rst = 1'b0;
        countBusy(n);
        checkOutput("rst_sweep_len", n, 64);
        checkOutput("small_idle_after", int'(bus_s.busy), 0);

        applyStimulus(1'b0, 1'b0, 6'd0, 4'h0, 1'b1, 6'd0);
        tick();
        checkOutput("rd0_after_rst_valid", int'(bus.rvalid), 1);
        checkOutput("rd0_after_rst_data", int'(bus.rdata), 0);
        applyStimulus(1'b0, 1'b0, 6'd0, 4'h0, 1'b1, 6'd63);
        tick();
        checkOutput("rd63_after_rst_valid", int'(bus.rvalid), 1);
        checkOutput("rd63_after_rst_data", int'(bus.rdata), 0);

        // Write/read, back-to-back reads.
        applyStimulus(1'b0, 1'b1, 6'd0, 4'hF, 1'b0, 6'd0);
        tick();
        checkOutput("no_read_rvalid", int'(bus.rvalid), 0);
        applyStimulus(1'b0, 1'b1, 6'd4, 4'hA, 1'b0, 6'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 6'd0, 4'h0, 1'b1, 6'd0);
        tick();
        checkOutput("rd0_valid", int'(bus.rvalid), 1);
        checkOutput("rd0_data", int'(bus.rdata), 15);
        applyStimulus(1'b0, 1'b0, 6'd0, 4'h0, 1'b1, 6'd4);
        tick();
        checkOutput("rd4_valid", int'(bus.rvalid), 1);
        checkOutput("rd4_data", int'(bus.rdata), 10);
        applyStimulus(1'b0, 1'b0, 6'd0, 4'h0, 1'b0, 6'd0);
        tick();
        checkOutput("idle_rvalid", int'(bus.rvalid), 0);
        checkOutput("idle_rdata_hold", int'(bus.rdata), 10);

        // Same-address collision is write-first.
        applyStimulus(1'b0, 1'b1, 6'd7, 4'h5, 1'b1, 6'd7);
        tick();
        checkOutput("collide_valid", int'(bus.rvalid), 1);
        checkOutput("collide_data", int'(bus.rdata), 5);
        applyStimulus(1'b0, 1'b0, 6'd0, 4'h0, 1'b1, 6'd7);
        tick();
        checkOutput("collide_stored", int'(bus.rdata), 5);

        // clr with a pending write, plus accesses and clr during the sweep.
        applyStimulus(1'b0, 1'b1, 6'd10, 4'hC, 1'b0, 6'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 6'd0, 4'h0, 1'b1, 6'd10);
        tick();
        checkOutput("rd10_before_clr", int'(bus.rdata), 12);
        applyStimulus(1'b1, 1'b1, 6'd11, 4'h6, 1'b0, 6'd0);
        tick();
        checkOutput("clr_busy", int'(bus.busy), 1);
        n = 0;
        for (int i = 0; i < 200 && bus.busy; i++) begin
            n++;
            if (i == 2)
                applyStimulus(1'b0, 1'b1, 6'd3, 4'h9, 1'b1, 6'd3);
            else if (i == 20)
                applyStimulus(1'b1, 1'b0, 6'd0, 4'h0, 1'b0, 6'd0);
            else
                applyStimulus(1'b0, 1'b0, 6'd0, 4'h0, 1'b0, 6'd0);
            tick();
            if (i == 2) begin
                checkOutput("busy_read_rvalid", int'(bus.rvalid), 0);
                checkOutput("busy_rdata_hold", int'(bus.rdata), 12);
            end
        end
        checkOutput("clr_sweep_len", n, 64);
        applyStimulus(1'b0, 1'b0, 6'd0, 4'h0, 1'b1, 6'd3);
        tick();
        checkOutput("rd3_after_clr_valid", int'(bus.rvalid), 1);
        checkOutput("rd3_after_clr_data", int'(bus.rdata), 0);
        applyStimulus(1'b0, 1'b0, 6'd0, 4'h0, 1'b1, 6'd10);
        tick();
        checkOutput("rd10_after_clr", int'(bus.rdata), 0);
        applyStimulus(1'b0, 1'b0, 6'd0, 4'h0, 1'b1, 6'd11);
        tick();
        checkOutput("rd11_after_clr", int'(bus.rdata), 0);

        // rst mid-sweep restarts the full sweep.
        applyStimulus(1'b0, 1'b1, 6'd20, 4'h7, 1'b1, 6'd0);
        tick();
        applyStimulus(1'b1, 1'b0, 6'd0, 4'h0, 1'b0, 6'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 6'd0, 4'h0, 1'b0, 6'd0);
        for (int i = 0; i < 29; i++) tick();
        checkOutput("mid_sweep_busy", int'(bus.busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid_rst_rdata", int'(bus.rdata), 0);
        checkOutput("mid_rst_rvalid", int'(bus.rvalid), 0);
        countBusy(n);
        checkOutput("mid_rst_sweep_len", n, 64);
        applyStimulus(1'b0, 1'b0, 6'd0, 4'h0, 1'b1, 6'd20);
        tick();
        checkOutput("rd20_after_mid_rst", int'(bus.rdata), 0);

        // DEPTH=40 instance: top word works, addresses >= 40 are dropped.
        applyStimulus(1'b0, 1'b0, 6'd0, 4'h0, 1'b0, 6'd0);
        applyStimulusS(1'b1, 6'd39, 4'h3, 1'b0, 6'd0);
        tick();
        applyStimulusS(1'b1, 6'd50, 4'hF, 1'b1, 6'd39);
        tick();
        checkOutput("small_rd39_valid", int'(bus_s.rvalid), 1);
        checkOutput("small_rd39_data", int'(bus_s.rdata), 3);
        applyStimulusS(1'b0, 6'd0, 4'h0, 1'b1, 6'd50);
        tick();
        checkOutput("small_rd50_valid", int'(bus_s.rvalid), 1);
        checkOutput("small_rd50_data", int'(bus_s.rdata), 0);
        applyStimulusS(1'b1, 6'd45, 4'hE, 1'b1, 6'd45);
        tick();
        checkOutput("small_collide_oor", int'(bus_s.rdata), 0);
        applyStimulusS(1'b0, 6'd0, 4'h0, 1'b1, 6'd39);
        tick();
        checkOutput("small_rd39_kept", int'(bus_s.rdata), 3);

        applyStimulusS(1'b0, 6'd0, 4'h0, 1'b0, 6'd0);
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
